// File: rtl/block_rw_pkg.sv
// Shared types for the block read/write AFU path: a minimal CCI-P channel-1 subset,
// cache-line geometry, write-engine state encoding and byte/line address helpers.
package block_rw_pkg;

  localparam int unsigned WORDS_PER_CL  = 8;
  localparam int unsigned CL_REQ_SIZE   = 64;
  localparam int unsigned WORD_IDX_BITS = $clog2(WORDS_PER_CL);

  // block_write_engine states
  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFill      = 3'd1;
  localparam logic [2:0] StIssue     = 3'd2;
  localparam logic [2:0] StDrain     = 3'd3;
  localparam logic [2:0] StDone      = 3'd4;
  localparam logic [2:0] StFence     = 3'd5;
  localparam logic [2:0] StFenceWait = 3'd6;

  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4, eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd6;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic               valid;
    logic [511:0]       data;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  function automatic logic cci_c1Rx_isWriteRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_WRLINE);
  endfunction

  function automatic logic cci_c1Rx_isWriteFenceRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_WRFENCE);
  endfunction

  function automatic t_ccip_clAddr byteAddrToClAddr(input logic [47:0] addr);
    return t_ccip_clAddr'(addr >> $clog2(CL_REQ_SIZE));
  endfunction

  function automatic logic [47:0] clAddrToByteAddr(input t_ccip_clAddr addr);
    return 48'(addr) << $clog2(CL_REQ_SIZE);
  endfunction

endpackage

// File: rtl/block_write_engine_packer.sv
// cl_word_packer: accumulates 64-bit words into one cache line, slot 0 first.
// line_next_o is the line including any word accepted this cycle.
module cl_word_packer
  import block_rw_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         word_valid_i,
  input  logic [63:0]                  word_i,
  input  logic                         flush_i,
  output logic                         line_end_o,
  output logic [WORDS_PER_CL*64-1:0]   line_next_o
);

  logic [WORD_IDX_BITS-1:0]   idx_q, idx_d;
  logic [WORDS_PER_CL*64-1:0] line_q, line_d;

  always_comb begin
    line_next_o = line_q;
    if (word_valid_i) begin
      line_next_o[64*idx_q +: 64] = word_i;
    end
    line_end_o = word_valid_i && (idx_q == WORD_IDX_BITS'(WORDS_PER_CL - 1));
    line_d     = flush_i ? '0 : line_next_o;
    idx_d      = flush_i ? '0 : (word_valid_i ? idx_q + WORD_IDX_BITS'(1) : idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      line_q <= '0;
    end else begin
      idx_q  <= idx_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/block_write_engine.sv
// Packs scan result words into cache lines and writes them over CCI-P channel 1.
// Optional BLOCK_WRITE_FENCE_EN: issue a WRFENCE after the last line is acked.
module block_write_engine
  import block_rw_pkg::*;
#(
  parameter int unsigned MAX_WORDS_BITS = 10,
  parameter int unsigned LINE_IDX_BITS  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  t_ccip_clAddr              wr_buff_address_i,
  input  logic [MAX_WORDS_BITS-1:0] total_words_i,
  input  logic                      in_valid_i,
  input  logic [63:0]               in_word_i,
  output logic                      in_ready_o,
  input  logic                      c1_tx_alm_full_i,
  output t_if_ccip_c1_Tx            c1_tx_o,
  input  t_if_ccip_c1_Rx            c1_rx_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [LINE_IDX_BITS-1:0]  lines_acked_o
);

  // One extra bit so a full 128-line block can be counted.
  localparam int unsigned CntBits = LINE_IDX_BITS + 1;

  logic [2:0]                state_q, state_d;
  t_ccip_clAddr              base_q, base_d;
  logic [MAX_WORDS_BITS-1:0] words_rem_q, words_rem_d;
  logic [CntBits-1:0]        lines_total_q, lines_total_d;
  logic [CntBits-1:0]        line_idx_q, line_idx_d;
  logic [CntBits-1:0]        acked_q, acked_d;
  t_if_ccip_c1_Tx            c1_tx_q, c1_tx_d;

  logic                      accept, flush, line_end, req_load;
  logic [WORDS_PER_CL*64-1:0] line_next;
  logic [MAX_WORDS_BITS:0]   words_rounded;

  assign words_rounded = {1'b0, total_words_i} + (MAX_WORDS_BITS + 1)'(WORDS_PER_CL - 1);
  assign in_ready_o    = (state_q == StFill);
  assign accept        = in_valid_i && in_ready_o;

  cl_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .word_valid_i (accept),
    .word_i       (in_word_i),
    .flush_i      (flush),
    .line_end_o   (line_end),
    .line_next_o  (line_next)
  );

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    words_rem_d   = words_rem_q;
    lines_total_d = lines_total_q;
    line_idx_d    = line_idx_q;
    acked_d       = acked_q;
    c1_tx_d       = c1_tx_q;
    c1_tx_d.valid = 1'b0;
    flush         = 1'b0;
    req_load      = 1'b0;

    if (state_q != StIdle && cci_c1Rx_isWriteRsp(c1_rx_i)) begin
      acked_d = acked_q + CntBits'(1);
    end

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          base_d        = wr_buff_address_i;
          words_rem_d   = total_words_i;
          lines_total_d = CntBits'(words_rounded >> WORD_IDX_BITS);
          line_idx_d    = '0;
          acked_d       = '0;
          flush         = 1'b1;
          state_d       = (total_words_i == '0) ? StDrain : StFill;
        end
      end
      StFill: begin
        if (accept) begin
          words_rem_d = words_rem_q - MAX_WORDS_BITS'(1);
          if (line_end || words_rem_q == MAX_WORDS_BITS'(1)) begin
            state_d  = StIssue;
            req_load = !c1_tx_alm_full_i;
          end
        end
      end
      StIssue: begin
        // The request register was loaded on entry or while waiting; valid is up now.
        if (c1_tx_q.valid) begin
          line_idx_d = line_idx_q + CntBits'(1);
          flush      = 1'b1;
          state_d    = (line_idx_q + CntBits'(1) == lines_total_q) ? StDrain : StFill;
        end else begin
          req_load = !c1_tx_alm_full_i;
        end
      end
      StDrain: begin
        if (acked_q == lines_total_q) begin
`ifdef BLOCK_WRITE_FENCE_EN
          state_d = StFence;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef BLOCK_WRITE_FENCE_EN
      StFence: begin
        if (c1_tx_q.valid) begin
          state_d = StFenceWait;
        end else if (!c1_tx_alm_full_i) begin
          c1_tx_d.valid         = 1'b1;
          c1_tx_d.hdr           = '0;
          c1_tx_d.hdr.vc_sel    = eVC_VA;
          c1_tx_d.hdr.req_type  = eREQ_WRFENCE;
          c1_tx_d.hdr.mdata     = '1;
        end
      end
      StFenceWait: begin
        if (cci_c1Rx_isWriteFenceRsp(c1_rx_i)) begin
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (req_load) begin
      c1_tx_d.valid        = 1'b1;
      c1_tx_d.hdr          = '0;
      c1_tx_d.hdr.vc_sel   = eVC_VA;
      c1_tx_d.hdr.req_type = eREQ_WRLINE_I;
      c1_tx_d.hdr.cl_len   = eCL_LEN_1;
      c1_tx_d.hdr.sop      = 1'b1;
      c1_tx_d.hdr.address  = base_q + t_ccip_clAddr'(line_idx_q);
      c1_tx_d.hdr.mdata    = t_ccip_mdata'(line_idx_q);
      c1_tx_d.data         = line_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      base_q        <= '0;
      words_rem_q   <= '0;
      lines_total_q <= '0;
      line_idx_q    <= '0;
      acked_q       <= '0;
      c1_tx_q       <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      words_rem_q   <= words_rem_d;
      lines_total_q <= lines_total_d;
      line_idx_q    <= line_idx_d;
      acked_q       <= acked_d;
      c1_tx_q       <= c1_tx_d;
    end
  end

  assign c1_tx_o       = c1_tx_q;
  assign busy_o        = (state_q != StIdle) && (state_q != StDone);
  assign done_o        = (state_q == StDone);
  assign lines_acked_o = acked_q[LINE_IDX_BITS-1:0];

endmodule

// File: tb/tb_block_write_engine.sv
// Randomized scoreboard bench for block_write_engine with a behavioural line model
// and a channel-1 responder returning write responses after random delays.
module tb_block_write_engine;
  import block_rw_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  t_ccip_clAddr   base_addr = '0;
  logic [9:0]     total_words = '0;
  logic           in_valid = 1'b0;
  logic [63:0]    in_word = '0;
  logic           in_ready;
  logic           alm_full = 1'b0;
  t_if_ccip_c1_Tx c1_tx;
  t_if_ccip_c1_Rx c1_rx = '0;
  logic           busy, done;
  logic [6:0]     lines_acked;

  block_write_engine dut (
    .clk               (clk),
    .reset             (reset),
    .start_i           (start),
    .wr_buff_address_i (base_addr),
    .total_words_i     (total_words),
    .in_valid_i        (in_valid),
    .in_word_i         (in_word),
    .in_ready_o        (in_ready),
    .c1_tx_alm_full_i  (alm_full),
    .c1_tx_o           (c1_tx),
    .c1_rx_i           (c1_rx),
    .busy_o            (busy),
    .done_o            (done),
    .lines_acked_o     (lines_acked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         fence;
    t_ccip_clAddr addr;
    logic [15:0]  mdata;
    logic [511:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  int          rsp_due_q[$];
  logic        rsp_fence_q[$];
  logic [63:0] words[$];
  int          writes_seen = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor and responder: pop expected request on every valid, then schedule its response.
  initial begin
    exp_t e;
    int   l;
    forever begin
      @(negedge clk);
      if (!reset && c1_tx.valid) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected request: got type %0h addr %0h, expected none (cycle %0d)",
                   c1_tx.hdr.req_type, c1_tx.hdr.address, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.fence) begin
            check("fence hdr", 512'({c1_tx.hdr.vc_sel, c1_tx.hdr.req_type, c1_tx.hdr.mdata}),
                  512'({eVC_VA, eREQ_WRFENCE, 16'hffff}));
            check("fence after all data rsps", 512'(rsp_due_q.size()), 512'(0));
          end else begin
            check("wrline hdr fields",
                  512'({c1_tx.hdr.vc_sel, c1_tx.hdr.req_type, c1_tx.hdr.cl_len, c1_tx.hdr.sop}),
                  512'({eVC_VA, eREQ_WRLINE_I, eCL_LEN_1, 1'b1}));
            check("wrline address", 512'(c1_tx.hdr.address), 512'(e.addr));
            check("wrline mdata", 512'(c1_tx.hdr.mdata), 512'(e.mdata));
            check("wrline data", c1_tx.data, e.data);
            if (lat_q.size() > 0) begin
              l = lat_q.pop_front();
              if (l >= 0) check("issue latency", 512'(cyc - l), 512'(1));
            end
          end
          rsp_due_q.push_back(cyc + int'($urandom_range(1, 8)));
          rsp_fence_q.push_back(e.fence);
        end
      end
      c1_rx = '0;
      if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
        c1_rx.rspValid       = 1'b1;
        c1_rx.hdr.resp_type  = rsp_fence_q[0] ? eRSP_WRFENCE : eRSP_WRLINE;
        c1_rx.hdr.mdata      = 16'($urandom);
        void'(rsp_due_q.pop_front());
        void'(rsp_fence_q.pop_front());
      end
    end
  end

  // Reference model: line l holds words 8l..8l+7 in slot order, zero beyond the block end.
  task automatic start_block(input t_ccip_clAddr b, input int n);
    exp_t e;
    int   nl;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
    nl = (n + WORDS_PER_CL - 1) / WORDS_PER_CL;
    for (int li = 0; li < nl; li++) begin
      e.fence = 1'b0;
      e.addr  = b + t_ccip_clAddr'(li);
      e.mdata = 16'(li);
      e.data  = '0;
      for (int k = 0; k < WORDS_PER_CL; k++) begin
        if (li * WORDS_PER_CL + k < n) e.data[64*k +: 64] = words[li * WORDS_PER_CL + k];
      end
      exp_q.push_back(e);
    end
`ifdef BLOCK_WRITE_FENCE_EN
    e.fence = 1'b1;
    e.addr  = '0;
    e.mdata = 16'hffff;
    e.data  = '0;
    exp_q.push_back(e);
`endif
    start       = 1'b1;
    base_addr   = b;
    total_words = 10'(n);
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic feed(input int n, input int rogue_at, input int alm_at);
    int                 tries;
    t_ccip_c1_ReqMemHdr snap;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_word  = words[i];
      start    = (i == rogue_at);
      if (i == alm_at) alm_full = 1'b1;
      tries = 0;
      while (!in_ready && tries < 300) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 300) begin
        tests++;
        fails++;
        $display("FAIL word accept timeout: word %0d not accepted, required within 300 cycles", i);
        in_valid = 1'b0;
        start    = 1'b0;
        alm_full = 1'b0;
        return;
      end
      if (i % WORDS_PER_CL == WORDS_PER_CL - 1 || i == n - 1) begin
        lat_q.push_back(i == alm_at ? -1 : cyc);
      end
      snap = c1_tx.hdr;
      @(negedge clk);
      start = 1'b0;
      if (i == alm_at) begin
        in_valid = 1'b0;
        for (int j = 0; j < 20; j++) begin
          check("almfull valid low", 512'(c1_tx.valid), 512'(0));
          check("almfull hdr stable", 512'(c1_tx.hdr), 512'(snap));
          check("almfull in_ready low", 512'(in_ready), 512'(0));
          @(negedge clk);
        end
        alm_full = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_block(input int n, input int w0);
    int t = 0;
    int nl;
    nl = (n + WORDS_PER_CL - 1) / WORDS_PER_CL;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done reached", 512'(done), 512'(1));
    check("busy after done", 512'(busy), 512'(0));
    check("lines_acked", 512'(lines_acked), 512'(7'(nl)));
    check("expected queue drained", 512'(exp_q.size()), 512'(0));
`ifdef BLOCK_WRITE_FENCE_EN
    check("requests issued", 512'(writes_seen - w0), 512'(nl + 1));
`else
    check("requests issued", 512'(writes_seen - w0), 512'(nl));
`endif
  endtask

  initial begin
    int w0;
    int n;
    t_ccip_clAddr b;

    repeat (3) @(negedge clk);
    check("reset c1tx valid", 512'(c1_tx.valid), 512'(0));
    check("reset c1tx hdr", 512'(c1_tx.hdr), 512'(0));
    check("reset c1tx data", c1_tx.data, 512'(0));
    check("reset in_ready/busy/done", 512'({in_ready, busy, done}), 512'(0));
    check("reset lines_acked", 512'(lines_acked), 512'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle in_ready/busy/done", 512'({in_ready, busy, done}), 512'(0));

    // 16 words, with a start pulse mid-block that must be ignored.
    w0 = writes_seen;
    start_block(42'h1000, 16);
    check("busy after start", 512'(busy), 512'(1));
    feed(16, 4, -1);
    finish_block(16, w0);

    // Partial last line.
    w0 = writes_seen;
    start_block(42'h2000, 11);
    feed(11, -1, -1);
    finish_block(11, w0);

    // Back-pressure while the first line waits in ISSUE.
    w0 = writes_seen;
    start_block(42'h3000, 16);
    feed(16, -1, 7);
    finish_block(16, w0);

    // Empty block.
    w0 = writes_seen;
    start_block(42'h4000, 0);
`ifndef BLOCK_WRITE_FENCE_EN
    check("empty block busy in drain", 512'({busy, done}), 512'(2'b10));
    @(negedge clk);
    check("empty block done next cycle", 512'({busy, done}), 512'(2'b01));
`endif
    finish_block(0, w0);

    // Reset after the first of three lines is issued.
    w0 = writes_seen;
    start_block(42'h5000, 24);
    feed(11, -1, -1);
    check("one line before reset", 512'(writes_seen - w0), 512'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid reset c1tx", 512'({c1_tx.valid, c1_tx.hdr}), 512'(0));
    check("mid reset data", c1_tx.data, 512'(0));
    check("mid reset status", 512'({in_ready, busy, done, lines_acked}), 512'(0));
    exp_q.delete();
    lat_q.delete();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("stale rsp ignored in idle", 512'(lines_acked), 512'(0));
    check("no request after reset", 512'(writes_seen - w0), 512'(1));
    w0 = writes_seen;
    start_block(42'h6000, 8);
    feed(8, -1, -1);
    finish_block(8, w0);

    // Random blocks, some with a base near the top of the address space.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      b = (r % 2 == 0) ? ~t_ccip_clAddr'($urandom_range(0, 3)) : t_ccip_clAddr'({$urandom, $urandom});
      w0 = writes_seen;
      start_block(b, n);
      feed(n, int'($urandom_range(0, n - 1)), (r == 3) ? n - 1 : -1);
      finish_block(n, w0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
